// File: rtl/sand_pkg.sv
// Shared types and default grid geometry for the falling-sand frame sequencer.
package sand_pkg;
  localparam int ACTIVE_COLUMNS = 640;
  localparam int ACTIVE_ROWS    = 480;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    SAND  = 2'b01,
    WATER = 2'b10
  } cell_t;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_START,
    S_RUN,
    S_COPY,
    S_COPY_LAST
  } seq_state_t;
endpackage

// File: rtl/sand_mem_port_mux.sv
// Combinational steering of both cell RAM ports between engine, copy, clear and draw sources.
module sand_mem_port_mux #(
  parameter int AW = 4,
  parameter int DW = 2
) (
  input  sand_pkg::seq_state_t state,
  input  logic          rst,
  input  logic [AW-1:0] seq_addr,
  input  logic          copy_wr_vld,
  input  logic [AW-1:0] copy_wr_addr,
  input  logic          draw_grant,
  input  logic [AW-1:0] draw_addr,
  input  logic [DW-1:0] draw_data,
  input  logic [AW-1:0] eng_vram_rd_addr,
  input  logic [AW-1:0] eng_ram_rd_addr,
  input  logic [AW-1:0] eng_vram_wr_addr,
  input  logic [AW-1:0] eng_ram_wr_addr,
  input  logic [DW-1:0] eng_vram_wr_data,
  input  logic [DW-1:0] eng_ram_wr_data,
  input  logic          eng_vram_wr_en,
  input  logic          eng_ram_wr_en,
  input  logic [DW-1:0] vram_rd_data,
  input  logic [DW-1:0] ram_rd_data,
  output logic [DW-1:0] eng_vram_rd_data,
  output logic [DW-1:0] eng_ram_rd_data,
  output logic [AW-1:0] vram_rd_addr,
  output logic [AW-1:0] ram_rd_addr,
  output logic [AW-1:0] vram_wr_addr,
  output logic [AW-1:0] ram_wr_addr,
  output logic [DW-1:0] vram_wr_data,
  output logic [DW-1:0] ram_wr_data,
  output logic          vram_wr_en,
  output logic          ram_wr_en
);
  import sand_pkg::*;

  always_comb begin
    vram_rd_addr     = '0;
    ram_rd_addr      = '0;
    vram_wr_addr     = '0;
    ram_wr_addr      = '0;
    vram_wr_data     = '0;
    ram_wr_data      = '0;
    vram_wr_en       = 1'b0;
    ram_wr_en        = 1'b0;
    eng_vram_rd_data = '0;
    eng_ram_rd_data  = '0;
    case (state)
      S_CLEAR: begin
        ram_wr_en   = 1'b1;
        ram_wr_addr = seq_addr;
      end
      S_IDLE: if (draw_grant) begin
        vram_wr_en   = 1'b1;
        vram_wr_addr = draw_addr;
        vram_wr_data = draw_data;
      end
      S_RUN: begin
        vram_rd_addr     = eng_vram_rd_addr;
        ram_rd_addr      = eng_ram_rd_addr;
        eng_vram_rd_data = vram_rd_data;
        eng_ram_rd_data  = ram_rd_data;
        if (eng_vram_wr_en) begin
          vram_wr_en   = 1'b1;
          vram_wr_addr = eng_vram_wr_addr;
          vram_wr_data = eng_vram_wr_data;
        end
        if (eng_ram_wr_en) begin
          ram_wr_en   = 1'b1;
          ram_wr_addr = eng_ram_wr_addr;
          ram_wr_data = eng_ram_wr_data;
        end
      end
      S_COPY, S_COPY_LAST: begin
        if (state == S_COPY) ram_rd_addr = seq_addr;
        // write stage trails the read by one cycle; scratch is zeroed behind it
        if (copy_wr_vld) begin
          vram_wr_en   = 1'b1;
          vram_wr_addr = copy_wr_addr;
          vram_wr_data = ram_rd_data;
          ram_wr_en    = 1'b1;
          ram_wr_addr  = copy_wr_addr;
        end
      end
      default: ;
    endcase
    if (rst) begin
      vram_wr_en   = 1'b0;
      ram_wr_en    = 1'b0;
      vram_wr_addr = '0;
      ram_wr_addr  = '0;
      vram_wr_data = '0;
      ram_wr_data  = '0;
    end
  end
endmodule

// File: rtl/sand_frame_sequencer.sv
// Per-frame scheduler: clears scratch, runs the cell engine, copies scratch into VRAM, grants draws.
module sand_frame_sequencer #(
  parameter int ACTIVE_COLUMNS = sand_pkg::ACTIVE_COLUMNS,
  parameter int ACTIVE_ROWS    = sand_pkg::ACTIVE_ROWS,
  parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS),
  parameter int DATA_WIDTH     = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  frame_tick_i,
  input  logic                  draw_req_i,
  input  logic [ADDR_WIDTH-1:0] draw_addr_i,
  input  logic [DATA_WIDTH-1:0] draw_data_i,
  output logic                  draw_ack_o,
  output logic                  eng_ready_o,
  input  logic                  eng_done_i,
  input  logic [ADDR_WIDTH-1:0] eng_vram_rd_addr_i,
  input  logic [ADDR_WIDTH-1:0] eng_ram_rd_addr_i,
  input  logic [ADDR_WIDTH-1:0] eng_vram_wr_addr_i,
  input  logic [ADDR_WIDTH-1:0] eng_ram_wr_addr_i,
  input  logic [DATA_WIDTH-1:0] eng_vram_wr_data_i,
  input  logic [DATA_WIDTH-1:0] eng_ram_wr_data_i,
  input  logic                  eng_vram_wr_en_i,
  input  logic                  eng_ram_wr_en_i,
  output logic [DATA_WIDTH-1:0] eng_vram_rd_data_o,
  output logic [DATA_WIDTH-1:0] eng_ram_rd_data_o,
  output logic [ADDR_WIDTH-1:0] vram_rd_addr_o,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr_o,
  output logic [ADDR_WIDTH-1:0] vram_wr_addr_o,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr_o,
  output logic [DATA_WIDTH-1:0] vram_wr_data_o,
  output logic [DATA_WIDTH-1:0] ram_wr_data_o,
  output logic                  vram_wr_en_o,
  output logic                  ram_wr_en_o,
  input  logic [DATA_WIDTH-1:0] vram_rd_data_i,
  input  logic [DATA_WIDTH-1:0] ram_rd_data_i,
  output logic                  busy_o,
  output logic                  overrun_o,
  output logic [15:0]           frame_count_o
);
  import sand_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(ACTIVE_COLUMNS*ACTIVE_ROWS - 1);

  seq_state_t            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  pending;
  logic                  copy_wr_vld;
  logic [ADDR_WIDTH-1:0] copy_wr_addr;
  logic                  go;
  logic                  draw_grant;

  assign busy_o      = (state != S_IDLE);
  assign go          = frame_tick_i | pending;
  assign draw_grant  = (state == S_IDLE) && !go && draw_req_i && !reset_i;
  assign draw_ack_o  = draw_grant;
  assign eng_ready_o = (state == S_START) && !reset_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state         <= S_CLEAR;
      addr          <= '0;
      pending       <= 1'b0;
      overrun_o     <= 1'b0;
      frame_count_o <= '0;
      copy_wr_vld   <= 1'b0;
      copy_wr_addr  <= '0;
    end else begin
      copy_wr_vld  <= (state == S_COPY);
      copy_wr_addr <= addr;
      // one tick may queue behind a busy frame; further ones are dropped and flagged
      if (frame_tick_i && busy_o) begin
        if (!pending) pending   <= 1'b1;
        else          overrun_o <= 1'b1;
      end
      case (state)
        S_CLEAR:
          if (addr == LAST) begin
            addr  <= '0;
            state <= S_IDLE;
          end else begin
            addr <= addr + 1'b1;
          end
        S_IDLE:
          if (go) begin
            pending <= 1'b0;
            state   <= S_START;
          end
        S_START: state <= S_RUN;
        S_RUN:
          if (eng_done_i) begin
            addr  <= '0;
            state <= S_COPY;
          end
        S_COPY:
          if (addr == LAST) state <= S_COPY_LAST;
          else              addr  <= addr + 1'b1;
        S_COPY_LAST: begin
          frame_count_o <= frame_count_o + 16'd1;
          addr          <= '0;
          state         <= S_IDLE;
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

  sand_mem_port_mux #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_mux (
    .state            (state),
    .rst              (reset_i),
    .seq_addr         (addr),
    .copy_wr_vld      (copy_wr_vld),
    .copy_wr_addr     (copy_wr_addr),
    .draw_grant       (draw_grant),
    .draw_addr        (draw_addr_i),
    .draw_data        (draw_data_i),
    .eng_vram_rd_addr (eng_vram_rd_addr_i),
    .eng_ram_rd_addr  (eng_ram_rd_addr_i),
    .eng_vram_wr_addr (eng_vram_wr_addr_i),
    .eng_ram_wr_addr  (eng_ram_wr_addr_i),
    .eng_vram_wr_data (eng_vram_wr_data_i),
    .eng_ram_wr_data  (eng_ram_wr_data_i),
    .eng_vram_wr_en   (eng_vram_wr_en_i),
    .eng_ram_wr_en    (eng_ram_wr_en_i),
    .vram_rd_data     (vram_rd_data_i),
    .ram_rd_data      (ram_rd_data_i),
    .eng_vram_rd_data (eng_vram_rd_data_o),
    .eng_ram_rd_data  (eng_ram_rd_data_o),
    .vram_rd_addr     (vram_rd_addr_o),
    .ram_rd_addr      (ram_rd_addr_o),
    .vram_wr_addr     (vram_wr_addr_o),
    .ram_wr_addr      (ram_wr_addr_o),
    .vram_wr_data     (vram_wr_data_o),
    .ram_wr_data      (ram_wr_data_o),
    .vram_wr_en       (vram_wr_en_o),
    .ram_wr_en        (ram_wr_en_o)
  );
endmodule

// File: tb/tb_sand_frame_sequencer.sv
// Directed bench for the frame sequencer on a 4x3 grid with behavioural 1-cycle-latency RAMs.
module tb_sand_frame_sequencer;
  localparam int N  = 12;
  localparam int AW = 4;
  localparam int DW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_i = 1'b1, frame_tick = 1'b0, draw_req = 1'b0, eng_done = 1'b0;
  logic [AW-1:0] draw_addr = '0;
  logic [DW-1:0] draw_data = '0;
  logic          draw_ack, eng_ready, busy, overrun;
  logic [15:0]   frame_count;
  logic [AW-1:0] e_vrd_addr = '0, e_rrd_addr = '0, e_vwr_addr = '0, e_rwr_addr = '0;
  logic [DW-1:0] e_vwr_data = '0, e_rwr_data = '0;
  logic          e_vwr_en = 1'b0, e_rwr_en = 1'b0;
  logic [DW-1:0] e_vrd_data, e_rrd_data;
  logic [AW-1:0] vrd_addr, rrd_addr, vwr_addr, rwr_addr;
  logic [DW-1:0] vwr_data, rwr_data;
  logic          vwr_en, rwr_en;
  logic [DW-1:0] vrd_data = '0, rrd_data = '0;

  logic          fill = 1'b1;
  logic [DW-1:0] vmem [0:N-1];
  logic [DW-1:0] rmem [0:N-1];

  int n_chk = 0;
  int n_err = 0;
  int cyc, acks;

  sand_frame_sequencer #(.ACTIVE_COLUMNS(4), .ACTIVE_ROWS(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .reset_i(reset_i), .frame_tick_i(frame_tick),
    .draw_req_i(draw_req), .draw_addr_i(draw_addr), .draw_data_i(draw_data), .draw_ack_o(draw_ack),
    .eng_ready_o(eng_ready), .eng_done_i(eng_done),
    .eng_vram_rd_addr_i(e_vrd_addr), .eng_ram_rd_addr_i(e_rrd_addr),
    .eng_vram_wr_addr_i(e_vwr_addr), .eng_ram_wr_addr_i(e_rwr_addr),
    .eng_vram_wr_data_i(e_vwr_data), .eng_ram_wr_data_i(e_rwr_data),
    .eng_vram_wr_en_i(e_vwr_en), .eng_ram_wr_en_i(e_rwr_en),
    .eng_vram_rd_data_o(e_vrd_data), .eng_ram_rd_data_o(e_rrd_data),
    .vram_rd_addr_o(vrd_addr), .ram_rd_addr_o(rrd_addr),
    .vram_wr_addr_o(vwr_addr), .ram_wr_addr_o(rwr_addr),
    .vram_wr_data_o(vwr_data), .ram_wr_data_o(rwr_data),
    .vram_wr_en_o(vwr_en), .ram_wr_en_o(rwr_en),
    .vram_rd_data_i(vrd_data), .ram_rd_data_i(rrd_data),
    .busy_o(busy), .overrun_o(overrun), .frame_count_o(frame_count)
  );

  // scratch RAM starts dirty so the clear pass is observable
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < N; i++) begin
        rmem[i] <= 2'b01;
        vmem[i] <= 2'b00;
      end
    end else begin
      if (rwr_en && rwr_addr < AW'(N)) rmem[rwr_addr] <= rwr_data;
      if (vwr_en && vwr_addr < AW'(N)) vmem[vwr_addr] <= vwr_data;
    end
    rrd_data <= (rrd_addr < AW'(N)) ? rmem[rrd_addr] : '0;
    vrd_data <= (vrd_addr < AW'(N)) ? vmem[vrd_addr] : '0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit ram_zero();
    for (int i = 0; i < N; i++) if (rmem[i] != 2'b00) return 1'b0;
    return 1'b1;
  endfunction

  // run until IDLE, counting cycles spent busy and any draw acks seen meanwhile
  task automatic wait_idle(output int c, output int a);
    c = 0;
    a = 0;
    while (busy && c < 100) begin
      if (draw_ack) a++;
      step();
      c++;
    end
  endtask

  task automatic end_frame(output int c, output int a);
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    wait_idle(c, a);
  endtask

  initial begin
    step();
    fill = 1'b0;
    step();
    chk("rst_busy", 32'(busy), 1);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_frame_count", 32'(frame_count), 0);
    chk("rst_ram_we", 32'(rwr_en), 0);
    chk("rst_ready", 32'(eng_ready), 0);

    // 1: clear pass
    reset_i = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      chk("clr_we", 32'(rwr_en), 1);
      chk("clr_addr", 32'(rwr_addr), i);
      chk("clr_data", 32'(rwr_data), 0);
      step();
    end
    chk("clr_idle", 32'(busy), 0);
    chk("clr_ram_zero", 32'(ram_zero()), 1);

    // 2: one frame with an engine write to ram[9]
    e_rwr_en = 1'b1; e_rwr_addr = 4'd9; e_rwr_data = 2'b01;
    #1 chk("idle_eng_we_ignored", 32'(rwr_en), 0);
    e_rwr_en = 1'b0;
    chk("idle_eng_rd_zero", 32'(e_rrd_data), 0);
    frame_tick = 1'b1;
    #1 chk("t2_ready_tick_cycle", 32'(eng_ready), 0);
    step();
    frame_tick = 1'b0;
    #1 chk("t2_ready", 32'(eng_ready), 1);
    step();
    chk("t2_ready_once", 32'(eng_ready), 0);
    e_rwr_en = 1'b1; e_rwr_addr = 4'd9; e_rwr_data = 2'b01;
    #1 chk("t2_run_we", 32'(rwr_en), 1);
    chk("t2_run_waddr", 32'(rwr_addr), 9);
    chk("t2_run_wdata", 32'(rwr_data), 1);
    step();
    e_rwr_en = 1'b0; e_rwr_addr = '0; e_rwr_data = '0; e_rrd_addr = 4'd9;
    #1 chk("t2_run_raddr", 32'(rrd_addr), 9);
    step();
    chk("t2_run_rdata", 32'(e_rrd_data), 1);
    e_rrd_addr = '0;
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    chk("t2_copy_rd0", 32'(rrd_addr), 0);
    chk("t2_copy_no_first_wr", 32'(vwr_en), 0);
    wait_idle(cyc, acks);
    chk("t2_copy_cycles", cyc, 13);
    chk("t2_vram9", 32'(vmem[9]), 1);
    chk("t2_vram8", 32'(vmem[8]), 0);
    chk("t2_ram_zero", 32'(ram_zero()), 1);
    chk("t2_frame_count", 32'(frame_count), 1);

    // 3: draw in IDLE, draw held off during a frame
    draw_req = 1'b1; draw_addr = 4'd5; draw_data = 2'b10;
    #1 chk("t3_ack", 32'(draw_ack), 1);
    chk("t3_vwe", 32'(vwr_en), 1);
    chk("t3_vaddr", 32'(vwr_addr), 5);
    chk("t3_vdata", 32'(vwr_data), 2);
    step();
    draw_req = 1'b0;
    chk("t3_vram5", 32'(vmem[5]), 2);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    draw_req = 1'b1;
    #1 chk("t3_start_no_ack", 32'(draw_ack), 0);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("t3_run_no_ack", 32'(draw_ack), 0);
      chk("t3_run_no_vwe", 32'(vwr_en), 0);
      step();
    end
    end_frame(cyc, acks);
    chk("t3_copy_acks", acks, 0);
    chk("t3_ack_after", 32'(draw_ack), 1);
    chk("t3_frame_count", 32'(frame_count), 2);
    step();
    draw_req = 1'b0;

    // 4: two ticks while running -> pending then overrun
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    chk("t4_overrun_one", 32'(overrun), 0);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    chk("t4_overrun", 32'(overrun), 1);
    end_frame(cyc, acks);
    chk("t4_copy_cycles", cyc, 13);
    chk("t4_frame_count", 32'(frame_count), 3);
    step();
    chk("t4_pending_start", 32'(eng_ready), 1);
    step();
    end_frame(cyc, acks);
    chk("t4_frame_count2", 32'(frame_count), 4);

    // 5: tick and draw in the same IDLE cycle
    frame_tick = 1'b1; draw_req = 1'b1; draw_addr = 4'd3; draw_data = 2'b01;
    #1 chk("t5_no_ack", 32'(draw_ack), 0);
    chk("t5_no_vwe", 32'(vwr_en), 0);
    step();
    frame_tick = 1'b0;
    #1 chk("t5_ready", 32'(eng_ready), 1);
    step();
    end_frame(cyc, acks);
    chk("t5_copy_acks", acks, 0);
    chk("t5_ack_after", 32'(draw_ack), 1);
    step();
    draw_req = 1'b0;
    chk("t5_vram3", 32'(vmem[3]), 1);
    chk("t5_frame_count", 32'(frame_count), 5);

    // 6: reset in the middle of COPY
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("t6_copy_addr", 32'(rrd_addr), 6);
    reset_i = 1'b1;
    #1 chk("t6_rst_no_vwe", 32'(vwr_en), 0);
    step();
    reset_i = 1'b0;
    #1 chk("t6_busy", 32'(busy), 1);
    chk("t6_no_vwe", 32'(vwr_en), 0);
    chk("t6_clear_we", 32'(rwr_en), 1);
    chk("t6_clear_addr", 32'(rwr_addr), 0);
    chk("t6_overrun", 32'(overrun), 0);
    chk("t6_frame_count", 32'(frame_count), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
